// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MAR/MDR initiator sequencing one read or write per request into a 512x32 async-read RAM.
// Optional address fault checking is enabled with `define MEM_ACCESS_ADDR_FAULT_EN.
module mem_access_ctrl #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata_out,
    output logic              fault,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t            state, state_nx;
    logic              op_wr;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic              req;
    logic              bad_addr;

    assign req = rd_req | wr_req;

`ifdef MEM_ACCESS_ADDR_FAULT_EN
    logic fault_q;
    assign bad_addr = |addr_in[DATA_W-1:ADDR_W];
    // Refused requests set the flag; the next accepted request clears it.
    always_ff @(posedge clock or posedge clear)
        if (clear)
            fault_q <= 1'b0;
        else if (state == IDLE && req)
            fault_q <= bad_addr;
    assign fault = fault_q;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_in[DATA_W-1:ADDR_W];
    assign bad_addr       = 1'b0;
    assign fault          = 1'b0;
`endif

    always_ff @(posedge clock or posedge clear)
        if (clear)
            state <= IDLE;
        else
            state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = bad_addr ? DONE : SETUP;
            SETUP:   state_nx = ACCESS;
            ACCESS:  state_nx = (cnt == '0) ? DONE : ACCESS;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear)
        if (clear) begin
            mar   <= '0;
            mdr   <= '0;
            cnt   <= '0;
            op_wr <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (req && !bad_addr) begin
                        mar   <= addr_in[ADDR_W-1:0];
                        op_wr <= !rd_req;
                        if (!rd_req)
                            mdr <= wdata_in;
                    end
                SETUP:
                    cnt <= 4'(WAIT_CYCLES - 1);
                ACCESS: begin
                    cnt <= cnt - 4'd1;
                    // Read data is sampled only on the final strobe edge.
                    if (cnt == '0 && !op_wr)
                        mdr <= mem_rdata;
                end
                default: ;
            endcase
        end

    assign busy        = state != IDLE;
    assign done        = state == DONE;
    assign mem_read    = (state == ACCESS) && !op_wr;
    assign mem_write   = (state == ACCESS) && op_wr;
    assign mem_address = mar;
    assign mem_wdata   = mdr;
    assign rdata_out   = mdr;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl (WAIT_CYCLES=1 main instance, WAIT_CYCLES=4 second instance).
module tb_mem_access_ctrl;
    localparam int AW = 9;
    localparam int DW = 32;

    typedef struct packed {
        logic          wr;
        logic          flt;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    logic          clock = 1'b0;
    logic          clear;
    logic          rd_req, wr_req;
    logic [DW-1:0] addr_in, wdata_in, mem_rdata, rdata_out, mem_wdata;
    logic          busy, done, fault, mem_read, mem_write;
    logic [AW-1:0] mem_address;

    logic          rd_req4;
    logic [DW-1:0] addr_in4, mem_rdata4, rdata_out4, mem_wdata4;
    logic          busy4, done4, fault4, mem_read4, mem_write4;
    logic [AW-1:0] mem_address4;

    logic [DW-1:0] ram [0:511];
    exp_t          q[$];
    int            total = 0;
    int            bad = 0;
    int            strobe_n = 0;

    always #5 clock = ~clock;

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut (
        .clock(clock), .clear(clear), .rd_req(rd_req), .wr_req(wr_req),
        .addr_in(addr_in), .wdata_in(wdata_in), .busy(busy), .done(done),
        .rdata_out(rdata_out), .fault(fault), .mem_read(mem_read),
        .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(4)) dut4 (
        .clock(clock), .clear(clear), .rd_req(rd_req4), .wr_req(1'b0),
        .addr_in(addr_in4), .wdata_in(32'h0), .busy(busy4), .done(done4),
        .rdata_out(rdata_out4), .fault(fault4), .mem_read(mem_read4),
        .mem_write(mem_write4), .mem_address(mem_address4),
        .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4)
    );

    // Junk value when not reading, so a mistimed MDR capture is visible.
    assign mem_rdata  = mem_read ? ram[mem_address] : 32'hBAD0_BAD0;
    assign mem_rdata4 = mem_read4 ? ram[mem_address4] : 32'hBAD0_BAD0;

    always @(posedge clock)
        if (mem_write)
            ram[mem_address] <= mem_wdata;

    always @(negedge clock) begin
        exp_t e;
        if (!clear) begin
            if (mem_read || mem_write) begin
                strobe_n++;
                total++;
                if (q.size() == 0 || mem_write !== q[0].wr || mem_read !== !q[0].wr ||
                    mem_address !== q[0].a || (q[0].wr && mem_wdata !== q[0].d)) begin
                    bad++;
                    $display("FAIL strobe: rd=%b wr=%b addr=%h wdata=%h pending=%0d", mem_read, mem_write, mem_address, mem_wdata, q.size());
                end
            end
            if (done) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL done: unexpected done pulse, no access pending");
                end else begin
                    e = q.pop_front();
                    if (strobe_n !== (e.flt ? 0 : 1) || fault !== e.flt || (!e.wr && !e.flt && rdata_out !== e.d)) begin
                        bad++;
                        $display("FAIL done: strobes=%0d fault=%b rdata=%h, want strobes=%0d fault=%b rdata=%h",
                                 strobe_n, fault, rdata_out, e.flt ? 0 : 1, e.flt, e.d);
                    end
                end
                strobe_n = 0;
            end
        end
    end

    task automatic req(input logic r, input logic w, input logic [DW-1:0] a, input logic [DW-1:0] d);
        @(negedge clock);
        rd_req = r; wr_req = w; addr_in = a; wdata_in = d;
        @(negedge clock);
        rd_req = 1'b0; wr_req = 1'b0;
    endtask

    task automatic wait_idle;
        int i = 0;
        while (busy && i < 20) begin
            @(negedge clock);
            i++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, i);
        end
        @(negedge clock);
    endtask

    task automatic test_reset;
        clear = 1'b1; rd_req = 0; wr_req = 0; addr_in = 0; wdata_in = 0; rd_req4 = 0; addr_in4 = 0;
        #12;
        total++;
        if ({busy, done, fault, mem_read, mem_write} !== 5'b0 || mem_address !== '0 || mem_wdata !== '0 ||
            rdata_out !== '0 || busy4 !== 1'b0 || rdata_out4 !== '0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b fault=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h, want all 0",
                     busy, done, fault, mem_read, mem_write, mem_address, mem_wdata, rdata_out);
        end
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic test_write_read;
        q.push_back({1'b1, 1'b0, 9'h005, 32'hDEADBEEF});
        req(0, 1, 32'h5, 32'hDEADBEEF);
        total++;
        if (busy !== 1'b1 || mem_write !== 1'b0 || mem_read !== 1'b0 || mem_address !== 9'h005) begin
            bad++;
            $display("FAIL setup: busy=%b wr=%b rd=%b addr=%h, want 1 0 0 005", busy, mem_write, mem_read, mem_address);
        end
        @(negedge clock);
        total++;
        if (mem_write !== 1'b1) begin
            bad++;
            $display("FAIL access_wr: mem_write=%b, want 1", mem_write);
        end
        @(negedge clock);
        total++;
        if (done !== 1'b1 || mem_write !== 1'b0 || mem_wdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL done_wr: done=%b wr=%b wdata=%h, want 1 0 deadbeef", done, mem_write, mem_wdata);
        end
        @(negedge clock);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_wr: busy=%b done=%b, want 0 0", busy, done);
        end
        q.push_back({1'b0, 1'b0, 9'h005, 32'hDEADBEEF});
        req(1, 0, 32'h5, 32'h0);
        wait_idle();
        total++;
        if (rdata_out !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL read_back: rdata=%h, want deadbeef", rdata_out);
        end
    endtask

    task automatic test_simultaneous;
        q.push_back({1'b0, 1'b0, 9'h1FF, 32'hA5A50001});
        req(1, 1, 32'h1FF, 32'h12345678);
        wait_idle();
        total++;
        if (rdata_out !== 32'hA5A50001 || ram[9'h1FF] !== 32'hA5A50001) begin
            bad++;
            $display("FAIL simultaneous: rdata=%h ram=%h, want a5a50001 a5a50001", rdata_out, ram[9'h1FF]);
        end
    endtask

    task automatic test_ignore_busy;
        int n = 0;
        q.push_back({1'b0, 1'b0, 9'h003, 32'h33330003});
        req(1, 0, 32'h3, 32'h0);
        rd_req = 1'b1; addr_in = 32'h4;
        @(negedge clock); n += int'(done);
        @(negedge clock); n += int'(done); rd_req = 1'b0;
        repeat (4) begin @(negedge clock); n += int'(done); end
        total++;
        if (n != 1 || rdata_out !== 32'h33330003) begin
            bad++;
            $display("FAIL ignore_busy: done pulses=%0d rdata=%h, want 1 33330003", n, rdata_out);
        end
    endtask

    task automatic test_back_to_back;
        q.push_back({1'b1, 1'b0, 9'h020, 32'hAAAA0020});
        req(0, 1, 32'h20, 32'hAAAA0020);
        @(negedge clock);
        @(negedge clock);
        q.push_back({1'b1, 1'b0, 9'h021, 32'hBBBB0021});
        wr_req = 1'b1; addr_in = 32'h21; wdata_in = 32'hBBBB0021;
        @(negedge clock);
        @(negedge clock);
        wr_req = 1'b0;
        total++;
        if (busy !== 1'b1 || mem_address !== 9'h021) begin
            bad++;
            $display("FAIL back_to_back: busy=%b addr=%h, want 1 021", busy, mem_address);
        end
        wait_idle();
        total++;
        if (ram[9'h020] !== 32'hAAAA0020 || ram[9'h021] !== 32'hBBBB0021) begin
            bad++;
            $display("FAIL b2b_ram: ram20=%h ram21=%h, want aaaa0020 bbbb0021", ram[9'h020], ram[9'h021]);
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        q.push_back({1'b0, 1'b0, 9'h010, 32'h10101010});
        req(1, 0, 32'h10, 32'h0);
        @(negedge clock);
        #1 clear = 1'b1;
        #1;
        total++;
        if (mem_read !== 1'b0 || busy !== 1'b0 || rdata_out !== '0 || done !== 1'b0 || mem_address !== '0) begin
            bad++;
            $display("FAIL reset_mid: rd=%b busy=%b rdata=%h done=%b addr=%h, want 0 0 0 0 0", mem_read, busy, rdata_out, done, mem_address);
        end
        q.delete();
        strobe_n = 0;
        @(negedge clock);
        clear = 1'b0;
        repeat (4) begin @(negedge clock); n += int'(done); end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL reset_mid_done: done pulses=%0d, want 0", n);
        end
    endtask

    task automatic test_wait4;
        int n = 0;
        @(negedge clock);
        rd_req4 = 1'b1; addr_in4 = 32'hA;
        @(negedge clock);
        rd_req4 = 1'b0;
        total++;
        if (busy4 !== 1'b1 || mem_read4 !== 1'b0 || mem_address4 !== 9'h00A) begin
            bad++;
            $display("FAIL w4_setup: busy=%b rd=%b addr=%h, want 1 0 00a", busy4, mem_read4, mem_address4);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n += int'(mem_read4);
            if (i == 1) ram[9'h00A] = 32'h0A0A0002;
        end
        total++;
        if (n != 4 || done4 !== 1'b0 || rdata_out4 !== '0) begin
            bad++;
            $display("FAIL w4_access: strobe cycles=%0d done=%b rdata=%h, want 4 0 0", n, done4, rdata_out4);
        end
        @(negedge clock);
        total++;
        if (done4 !== 1'b1 || mem_read4 !== 1'b0 || rdata_out4 !== 32'h0A0A0002) begin
            bad++;
            $display("FAIL w4_done: done=%b rd=%b rdata=%h, want 1 0 0a0a0002", done4, mem_read4, rdata_out4);
        end
        @(negedge clock);
        total++;
        if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            bad++;
            $display("FAIL w4_idle: busy=%b done=%b, want 0 0", busy4, done4);
        end
    endtask

`ifdef MEM_ACCESS_ADDR_FAULT_EN
    task automatic test_fault;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        a0 = mem_address; d0 = mem_wdata;
        q.push_back({1'b1, 1'b1, 9'h000, 32'h0});
        req(0, 1, 32'h200, 32'h11111111);
        total++;
        if (done !== 1'b1 || fault !== 1'b1 || mem_write !== 1'b0 || mem_address !== a0 || mem_wdata !== d0) begin
            bad++;
            $display("FAIL fault_done: done=%b fault=%b wr=%b addr=%h wdata=%h, want 1 1 0 %h %h", done, fault, mem_write, mem_address, mem_wdata, a0, d0);
        end
        @(negedge clock);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || fault !== 1'b1) begin
            bad++;
            $display("FAIL fault_sticky: busy=%b done=%b fault=%b, want 0 0 1", busy, done, fault);
        end
        q.push_back({1'b0, 1'b0, 9'h001, 32'h00010001});
        req(1, 0, 32'h1, 32'h0);
        total++;
        if (fault !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL fault_clear: fault=%b busy=%b, want 0 1", fault, busy);
        end
        wait_idle();
    endtask
`else
    task automatic test_truncate;
        q.push_back({1'b1, 1'b0, 9'h005, 32'h5A5A5A5A});
        req(0, 1, 32'h205, 32'h5A5A5A5A);
        wait_idle();
        total++;
        if (fault !== 1'b0 || ram[9'h005] !== 32'h5A5A5A5A) begin
            bad++;
            $display("FAIL truncate: fault=%b ram5=%h, want 0 5a5a5a5a", fault, ram[9'h005]);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 32'h0;
        ram[9'h1FF] = 32'hA5A50001;
        ram[9'h003] = 32'h33330003;
        ram[9'h010] = 32'h10101010;
        ram[9'h001] = 32'h00010001;
        ram[9'h00A] = 32'h0A0A0001;
        test_reset();
        test_write_read();
        test_simultaneous();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_wait4();
`ifdef MEM_ACCESS_ADDR_FAULT_EN
        test_fault();
`else
        test_truncate();
`endif
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending=%0d, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- CPU-side initiator for the datapath's 512x32 asynchronous-read RAM. Holds MAR/MDR, sequences a single read or write per request, and drives the RAM's read/write/address/BusMuxOut pins.
- Returns read data through MDR to the datapath with a one-cycle done pulse.
- Sits between the control unit and the RAM. Strobes are registered and held stable for the whole access.

Parameters:
- ADDR_W, 9, RAM address width; MAR width.
- DATA_W, 32, data width of MDR and bus.
- WAIT_CYCLES, 1, cycles the strobe is held in ACCESS (range 1..15).

Ports:
- clock  in  1  single system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- rd_req  in  1  read request, sampled in IDLE only.
- wr_req  in  1  write request, sampled in IDLE only.
- addr_in  in  DATA_W  address from BusMuxOut; low ADDR_W bits load MAR.
- wdata_in  in  DATA_W  write data from BusMuxOut; loads MDR on wr_req.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse marking access completion.
- rdata_out  out  DATA_W  MDR contents, valid from done onward.
- fault  out  1  address fault flag (see Optional Feature).
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe.
- mem_address  out  ADDR_W  RAM address, equal to MAR.
- mem_wdata  out  DATA_W  RAM write data (BusMuxOut pin), equal to MDR.
- mem_rdata  in  DATA_W  RAM data out (Mdatain); may be Z when not reading.

Behaviour:
- Reset (clear=1, asynchronous):
  - state=IDLE; MAR=0; MDR=0; wait counter=0.
  - busy=0, done=0, fault=0, mem_read=0, mem_write=0.
  - mem_address=0, mem_wdata=0, rdata_out=0.
  - Strobes drop immediately, including when reset arrives mid-access. No partial MDR update occurs.
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered or decoded from state plus registers; there are no combinational paths from inputs to outputs.
- IDLE:
  - On rising edge with rd_req=1: MAR<=addr_in[ADDR_W-1:0], op=READ, go to SETUP.
  - Else if wr_req=1: MAR<=addr_in[ADDR_W-1:0], MDR<=wdata_in, op=WRITE, go to SETUP.
  - rd_req and wr_req both high: read wins; the write is dropped and not queued.
- SETUP (1 cycle): address is stable on mem_address with both strobes low, so the RAM sees the address before the strobe. Go to ACCESS and load wait counter=WAIT_CYCLES-1.
- ACCESS:
  - mem_read=1 (READ) or mem_write=1 (WRITE); never both.
  - Counter decrements each edge.
  - On the edge where counter==0, go to DONE. For READ, MDR<=mem_rdata on that same edge.
- DONE (1 cycle): done=1, strobes low, then go to IDLE.
- Latency: request sampled at edge E.
  - busy is high in the cycles after E through E+2+WAIT_CYCLES.
  - done is high for exactly the cycle after edge E+1+WAIT_CYCLES.
  - Default total occupancy is 3 cycles.
- Requests asserted while busy=1 are ignored, not queued. The control unit must re-issue them after done.
- MDR and MAR hold their values in IDLE. rdata_out persists until the next read completes or reset.
- A write never alters MDR after the request edge. mem_wdata is stable through SETUP, ACCESS and DONE.
- Back-to-back: a request present in the IDLE cycle directly after DONE is accepted. There are no bubbles beyond DONE.

Optional Feature:
- Macro MEM_ACCESS_ADDR_FAULT_EN.
- Defined:
  - In IDLE, a request with addr_in[DATA_W-1:ADDR_W] != 0 is refused: no SETUP/ACCESS, strobes stay low, MAR/MDR unchanged.
  - FSM goes directly to DONE, so done pulses the cycle after the request edge, with fault=1 in that same cycle.
  - fault is sticky until the next accepted request or clear.
- Undefined:
  - Upper address bits are silently truncated.
  - fault is tied to 0.

Test Plan:
- Write then read: wr_req with addr_in=0x05, wdata_in=0xDEADBEEF -> mem_write high exactly 1 cycle (WAIT_CYCLES=1) with mem_address=0x05 and mem_wdata=0xDEADBEEF; done at request+3. Then rd_req with addr 0x05 and RAM returning 0xDEADBEEF -> rdata_out=0xDEADBEEF at done.
- Simultaneous requests: rd_req=wr_req=1 at addr 0x1FF -> only mem_read asserts; mem_write stays 0 throughout; MDR loads read data.
- Ignored request while busy: rd_req pulsed during SETUP and during ACCESS -> no second access; exactly one done pulse.
- Reset mid-operation: clear asserted during ACCESS of a read -> mem_read falls without waiting for a clock edge; MDR=0; busy=0; no done pulse.
- WAIT_CYCLES=4 read of 0x00A -> mem_read high for 4 consecutive cycles; done at request+6; MDR captured on the final ACCESS edge.
- With MEM_ACCESS_ADDR_FAULT_EN: wr_req with addr_in=0x00000200 -> no strobe; done and fault high in the cycle after the request; then rd_req with 0x001 -> access proceeds and fault clears.
